// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the MIPS-subset core.
// Sequences fetch/decode/execute/memory/write-back and counts retired instructions.
module multicycle_control #(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] funct,
    input  logic           alu_zero,
    input  logic           mem_ready,
    output logic           pc_en,
    output logic [1:0]     pc_source,
    output logic           iord,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [3:0]     alu_ctrl,
    output logic           illegal_instr,
    output logic           instr_done,
    output logic [31:0]    retired
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC, S_ALU_WB, S_IMM_EXEC, S_IMM_WB, S_BRANCH, S_JUMP
    } state_e;

    localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

    localparam logic [OPW-1:0] FN_ADD = OPW'(6'b100000);
    localparam logic [OPW-1:0] FN_SUB = OPW'(6'b100010);
    localparam logic [OPW-1:0] FN_AND = OPW'(6'b100100);
    localparam logic [OPW-1:0] FN_OR  = OPW'(6'b100101);
    localparam logic [OPW-1:0] FN_SLT = OPW'(6'b101010);
    localparam logic [OPW-1:0] FN_NOR = OPW'(6'b100111);

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_e      state_q, state_d;
    logic [31:0] retired_q, retired_d;

    logic       is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_j;
    logic       funct_ok, legal;
    logic [3:0] alu_fn;

    always_comb begin
        is_r     = (opcode == OP_R);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_beq   = (opcode == OP_BEQ);
        is_bne   = (opcode == OP_BNE);
        is_addi  = (opcode == OP_ADDI);
        is_j     = (opcode == OP_J);
        funct_ok = 1'b1;
        alu_fn   = ALU_ADD;
        case (funct)
            FN_ADD:  alu_fn = ALU_ADD;
            FN_SUB:  alu_fn = ALU_SUB;
            FN_AND:  alu_fn = ALU_AND;
            FN_OR:   alu_fn = ALU_OR;
            FN_SLT:  alu_fn = ALU_SLT;
            FN_NOR:  alu_fn = ALU_NOR;
            default: funct_ok = 1'b0;
        endcase
        legal = is_r ? funct_ok
                     : (is_lw | is_sw | is_beq | is_bne | is_addi | is_j);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                // Illegal encodings skip straight to the next fetch
                if (!legal) begin
                    state_d = S_FETCH;
                end else begin
                    unique case (1'b1)
                        is_lw | is_sw:   state_d = S_MEM_ADDR;
                        is_r:            state_d = S_EXEC;
                        is_addi:         state_d = S_IMM_EXEC;
                        is_beq | is_bne: state_d = S_BRANCH;
                        is_j:            state_d = S_JUMP;
                        default:         state_d = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR: state_d = is_sw ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC:     state_d = S_ALU_WB;
            S_IMM_EXEC: state_d = S_IMM_WB;
            S_MEM_WB, S_ALU_WB, S_IMM_WB, S_BRANCH, S_JUMP:
                        state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_en         = 1'b0;
        pc_source     = 2'd0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_ctrl      = ALU_ADD;
        illegal_instr = 1'b0;
        instr_done    = 1'b0;
        unique case (state_q)
            S_IDLE:     alu_ctrl = 4'b0000;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                pc_en     = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b     = 2'd3;
                illegal_instr = !legal;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctrl  = alu_fn;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_IMM_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = ALU_SUB;
                pc_source  = 2'd1;
                pc_en      = is_bne ? !alu_zero : alu_zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_source  = 2'd2;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign retired_d = retired_q + {31'd0, instr_done};
    assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control.
// Output bundle is compared cycle by cycle against hand-written patterns.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode, funct;
    logic        alu_zero, mem_ready;
    logic        pc_en, iord, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic        illegal_instr, instr_done;
    logic [1:0]  pc_source, alu_src_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] retired;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_ret = '0;

    multicycle_control #(.OPW(6)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_en(pc_en),
        .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .illegal_instr(illegal_instr), .instr_done(instr_done),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // {pc_en,pc_source,iord,mem_read,mem_write,ir_write,reg_dst,
    //  mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_ctrl,illegal,done}
    logic [18:0] ctl;
    assign ctl = {pc_en, pc_source, iord, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                  alu_ctrl, illegal_instr, instr_done};

    localparam logic [18:0] C_IDLE = '0;
    localparam logic [18:0] C_FW   = {1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'd1, 4'b0010, 2'b00};
    localparam logic [18:0] C_FR   = {1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 2'd1, 4'b0010, 2'b00};
    localparam logic [18:0] C_DEC  = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'd3, 4'b0010, 2'b00};
    localparam logic [18:0] C_DECI = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'd3, 4'b0010, 2'b10};
    localparam logic [18:0] C_MA   = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'd2, 4'b0010, 2'b00};
    localparam logic [18:0] C_MR   = {1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 4'b0010, 2'b00};
    localparam logic [18:0] C_MWB  = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 2'd0, 4'b0010, 2'b01};
    localparam logic [18:0] C_MWW  = {1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 4'b0010, 2'b00};
    localparam logic [18:0] C_MWD  = {1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 4'b0010, 2'b01};
    localparam logic [18:0] C_AWB  = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 2'd0, 4'b0010, 2'b01};
    localparam logic [18:0] C_IE   = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'd2, 4'b0010, 2'b00};
    localparam logic [18:0] C_IWB  = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 2'd0, 4'b0010, 2'b01};
    localparam logic [18:0] C_J    = {1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 4'b0010, 2'b01};

    task automatic test_reset();
        rst_n = 1'b1; mem_ready = 1'b1; alu_zero = 1'b0;
        opcode = 6'b111111; funct = 6'd0;
        #1 rst_n = 1'b0;
        #2;
        total++;
        if (ctl !== C_IDLE || retired !== 32'd0) begin
            bad++;
            $display("FAIL reset_hold ctl=%h ret=%h want ctl=%h ret=0", ctl, retired, C_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (ctl !== C_IDLE) begin
            bad++;
            $display("FAIL reset_idle ctl=%h want %h", ctl, C_IDLE);
        end
    endtask

    task automatic test_rtype(input string nm, input logic [5:0] fn, input logic [3:0] alu);
        logic [18:0] e [4];
        e = '{C_FR, C_DEC, {13'b0000000000100, alu, 2'b00}, C_AWB};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin opcode = 6'b000000; funct = fn; end
            mem_ready = 1'b1;
            #1;
            total++;
            if (ctl !== e[i] || (i == 0 && retired !== exp_ret)) begin
                bad++;
                $display("FAIL %s[%0d] ctl=%h ret=%0d want ctl=%h ret=%0d", nm, i, ctl, retired, e[i], exp_ret);
            end
        end
        exp_ret++;
    endtask

    task automatic test_lw_wait();
        logic [18:0] e [7];
        logic        r [7];
        e = '{C_FR, C_DEC, C_MA, C_MR, C_MR, C_MR, C_MWB};
        r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) opcode = 6'b100011;
            mem_ready = r[i];
            #1;
            total++;
            if (ctl !== e[i] || (i == 0 && retired !== exp_ret)) begin
                bad++;
                $display("FAIL lw[%0d] ctl=%h ret=%0d want ctl=%h ret=%0d", i, ctl, retired, e[i], exp_ret);
            end
        end
        exp_ret++;
    endtask

    task automatic test_addi_fetch_wait();
        logic [18:0] e [5];
        logic        r [5];
        e = '{C_FW, C_FR, C_DEC, C_IE, C_IWB};
        r = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) opcode = 6'b001000;
            mem_ready = r[i];
            #1;
            total++;
            if (ctl !== e[i] || (i == 0 && retired !== exp_ret)) begin
                bad++;
                $display("FAIL addi[%0d] ctl=%h ret=%0d want ctl=%h ret=%0d", i, ctl, retired, e[i], exp_ret);
            end
        end
        exp_ret++;
    endtask

    task automatic test_sw();
        logic [18:0] e [4];
        e = '{C_FR, C_DEC, C_MA, C_MWD};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) opcode = 6'b101011;
            mem_ready = 1'b1;
            #1;
            total++;
            if (ctl !== e[i] || (i == 0 && retired !== exp_ret)) begin
                bad++;
                $display("FAIL sw[%0d] ctl=%h ret=%0d want ctl=%h ret=%0d", i, ctl, retired, e[i], exp_ret);
            end
        end
        exp_ret++;
    endtask

    task automatic test_branch(input string nm, input logic [5:0] op, input logic az, input logic pe);
        logic [18:0] e [3];
        e = '{C_FR, C_DEC, {pe, 2'd1, 7'b0000000, 1'b1, 2'd0, 4'b0110, 2'b01}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) opcode = op;
            mem_ready = 1'b1;
            alu_zero  = az;
            #1;
            total++;
            if (ctl !== e[i] || (i == 0 && retired !== exp_ret)) begin
                bad++;
                $display("FAIL %s[%0d] ctl=%h ret=%0d want ctl=%h ret=%0d", nm, i, ctl, retired, e[i], exp_ret);
            end
        end
        exp_ret++;
    endtask

    task automatic test_illegal(input string nm, input logic [5:0] op, input logic [5:0] fn);
        logic [18:0] e [2];
        e = '{C_FR, C_DECI};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) begin opcode = op; funct = fn; end
            mem_ready = 1'b1;
            #1;
            total++;
            if (ctl !== e[i] || (i == 0 && retired !== exp_ret)) begin
                bad++;
                $display("FAIL %s[%0d] ctl=%h ret=%0d want ctl=%h ret=%0d", nm, i, ctl, retired, e[i], exp_ret);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [18:0] e [4];
        logic        r [4];
        e = '{C_FR, C_DEC, C_MA, C_MWW};
        r = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) opcode = 6'b101011;
            mem_ready = r[i];
            #1;
            total++;
            if (ctl !== e[i] || (i == 0 && retired !== exp_ret)) begin
                bad++;
                $display("FAIL swrst[%0d] ctl=%h ret=%0d want ctl=%h ret=%0d", i, ctl, retired, e[i], exp_ret);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        exp_ret = '0;
        total++;
        if (ctl !== C_IDLE || retired !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid ctl=%h ret=%0d want ctl=0 ret=0", ctl, retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (ctl !== C_IDLE) begin
            bad++;
            $display("FAIL rst_mid_idle ctl=%h want %h", ctl, C_IDLE);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if (ctl !== C_FW || retired !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_fetch ctl=%h ret=%0d want ctl=%h ret=0", ctl, retired, C_FW);
        end
    endtask

    task automatic test_wrap();
        logic [18:0] e [3];
        e = '{C_FR, C_DEC, C_J};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                opcode = 6'b000010;
                force dut.retired_q = 32'hFFFF_FFFF;
            end
            mem_ready = 1'b1;
            #1;
            if (i == 0) release dut.retired_q;
            total++;
            if (ctl !== e[i]) begin
                bad++;
                $display("FAIL jwrap[%0d] ctl=%h want %h", i, ctl, e[i]);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if (retired !== 32'd0 || instr_done !== 1'b0) begin
            bad++;
            $display("FAIL wrap ret=%h done=%b want ret=0 done=0", retired, instr_done);
        end
    endtask

    initial begin
        test_reset();
        test_rtype("add", 6'b100000, 4'b0010);
        test_lw_wait();
        test_addi_fetch_wait();
        test_sw();
        test_rtype("nor", 6'b100111, 4'b1100);
        test_rtype("slt", 6'b101010, 4'b0111);
        test_branch("beq_t", 6'b000100, 1'b1, 1'b1);
        test_branch("beq_nt", 6'b000100, 1'b0, 1'b0);
        test_branch("bne_t", 6'b000101, 1'b0, 1'b1);
        test_illegal("ill_op", 6'b111111, 6'b000000);
        test_illegal("ill_fn", 6'b000000, 6'b000001);
        test_rtype("sub", 6'b100010, 4'b0110);
        test_reset_mid_wait();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
